// File: rtl/spike_pkg.sv
// Shared types and constants for the spike rate decoder: FSM states and seven-segment widths.
package spike_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [6:0] SEG_ZERO = 7'h3F;
  localparam int         SEG_W    = 15;

endpackage

// File: rtl/spike_rate_decoder_hex_to_7seg.sv
// Combinational hex digit to active-high seven-segment pattern (a=bit0 .. g=bit6).
module hex_to_7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike rising edges per WINDOW clocks, latches the rate and shows it as two hex digits.
// Optional SPIKE_DECODER_ISI_EN adds last_isi: clocks between the two most recent spike edges.
module spike_rate_decoder
  import spike_pkg::*;
#(
  parameter logic [23:0] WINDOW = 24'd10_000_000,
  parameter int          CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spike_in,
  input  logic              en,
  output logic [CNT_W-1:0]  rate_count,
  // rate_valid: one-cycle strobe, no back-pressure; rate_count/seg_out are stable until the next strobe
  output logic              rate_valid,
  output logic [SEG_W-1:0]  seg_out,
`ifdef SPIKE_DECODER_ISI_EN
  output logic [15:0]       last_isi,
`endif
  output state_t            state_dbg
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, next_state;
  logic [23:0]       win_cnt;
  logic [CNT_W-1:0]  spk_cnt;
  logic [CNT_W-1:0]  spk_inc;
  logic              spike_prev;
  logic              spike_edge;
  logic [7:0]        disp_byte;
  logic [6:0]        seg_lo, seg_hi;

  assign spike_edge = spike_in & ~spike_prev;
  assign spk_inc    = (spk_cnt == CNT_MAX) ? spk_cnt
                                           : spk_cnt + {{(CNT_W-1){1'b0}}, spike_edge};
  assign state_dbg  = state;

  // Digits always show the low byte of the value about to be latched.
  generate
    if (CNT_W >= 8) begin : g_byte_wide
      assign disp_byte = spk_inc[7:0];
    end else begin : g_byte_narrow
      assign disp_byte = {{(8-CNT_W){1'b0}}, spk_inc};
    end
  endgenerate

  hex_to_7seg u_seg_lo (.hex(disp_byte[3:0]), .seg(seg_lo));
  hex_to_7seg u_seg_hi (.hex(disp_byte[7:4]), .seg(seg_hi));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en) next_state = COUNT;
      COUNT:   if (!en) next_state = IDLE;
               else if (win_cnt == WINDOW - 24'd2) next_state = LATCH;
      LATCH:   next_state = en ? COUNT : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spike_prev <= 1'b0;
      win_cnt    <= '0;
      spk_cnt    <= '0;
      rate_count <= '0;
      rate_valid <= 1'b0;
      seg_out    <= {1'b0, SEG_ZERO, SEG_ZERO};
    end else begin
      spike_prev <= spike_in;
      rate_valid <= 1'b0;
      case (state)
        COUNT: begin
          // Dropping en discards the partial window; the displayed rate holds.
          if (!en) begin
            win_cnt <= '0;
            spk_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 24'd1;
            spk_cnt <= spk_inc;
          end
        end
        LATCH: begin
          rate_count <= spk_inc;
          rate_valid <= 1'b1;
          seg_out    <= {(spk_inc == CNT_MAX), seg_hi, seg_lo};
          win_cnt    <= '0;
          spk_cnt    <= '0;
        end
        default: begin
          win_cnt <= '0;
          spk_cnt <= '0;
        end
      endcase
    end
  end

`ifdef SPIKE_DECODER_ISI_EN
  logic [15:0] isi_cnt;
  logic        isi_armed;

  // isi_cnt restarts at 0 on an edge, so the interval to the next edge is isi_cnt + 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b0;
      last_isi  <= '0;
    end else if (spike_edge) begin
      isi_cnt   <= '0;
      isi_armed <= 1'b1;
      if (isi_armed) last_isi <= (isi_cnt == 16'hFFFF) ? 16'hFFFF : isi_cnt + 16'd1;
    end else if (isi_cnt != 16'hFFFF) begin
      isi_cnt <= isi_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Directed bench for spike_rate_decoder: WINDOW=16 instance plus a WINDOW=1024 instance for saturation.
module tb_spike_rate_decoder;
  import spike_pkg::*;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             spike_in;
  logic             en;
  logic [CNT_W-1:0] rate_count, big_rate_count;
  logic             rate_valid, big_rate_valid;
  logic [14:0]      seg_out, big_seg_out;
  state_t           state_dbg, big_state_dbg;
`ifdef SPIKE_DECODER_ISI_EN
  logic [15:0]      last_isi, big_last_isi;
`endif

  int               n_vec  = 0;
  int               n_miss = 0;
  logic [CNT_W-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  spike_rate_decoder #(.WINDOW(24'd16), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .spike_in(spike_in), .en(en),
    .rate_count(rate_count), .rate_valid(rate_valid), .seg_out(seg_out),
`ifdef SPIKE_DECODER_ISI_EN
    .last_isi(last_isi),
`endif
    .state_dbg(state_dbg)
  );

  spike_rate_decoder #(.WINDOW(24'd1024), .CNT_W(CNT_W)) dut_big (
    .clk(clk), .rst(rst), .spike_in(spike_in), .en(en),
    .rate_count(big_rate_count), .rate_valid(big_rate_valid), .seg_out(big_seg_out),
`ifdef SPIKE_DECODER_ISI_EN
    .last_isi(big_last_isi),
`endif
    .state_dbg(big_state_dbg)
  );

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic hold_reset;
    rst = 1'b1; en = 1'b0; spike_in = 1'b0;
    repeat (3) tick();
  endtask

  // Release reset with en=1; after this tick both DUTs are in their first COUNT cycle.
  task automatic start_run;
    rst = 1'b0; en = 1'b1; spike_in = 1'b0;
    tick();
  endtask

  // Drive one 16-cycle window on the small DUT (slot 15 lands in LATCH) and score it.
  task automatic run_window(input string tag, input logic [15:0] pat,
                            input logic [CNT_W-1:0] exp_rate, input logic [14:0] exp_seg);
    int               early;
    logic [CNT_W-1:0] exp;
    early = 0;
    exp_q.push_back(exp_rate);
    for (int i = 0; i < 16; i++) begin
      spike_in = pat[i];
      tick();
      if (i < 15 && rate_valid) early++;
    end
    chk_eq({tag, "_early_valid"}, early, 0);
    chk_eq({tag, "_valid"}, {31'd0, rate_valid}, 1);
    exp = exp_q.pop_front();
    chk_eq({tag, "_rate"}, {24'd0, rate_count}, {24'd0, exp});
    chk_eq({tag, "_seg"}, {17'd0, seg_out}, {17'd0, exp_seg});
  endtask

  // ---------------- scenario ----------------
  initial begin
    int cnt;

    // Reset values
    hold_reset();
    chk_eq("rst_rate", {24'd0, rate_count}, 0);
    chk_eq("rst_valid", {31'd0, rate_valid}, 0);
    chk_eq("rst_seg", {17'd0, seg_out}, 32'h1FBF);
    chk_eq("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
    chk_eq("rst_big_seg", {17'd0, big_seg_out}, 32'h1FBF);
    start_run();

    // Basic windows, period and digit decoding
    run_window("five",        16'h0155, 8'd5, 15'h1FED);
    run_window("zero",        16'h0000, 8'd0, 15'h1FBF);
    run_window("held",        16'h0FFC, 8'd1, 15'h1F86);
    run_window("latch_edge",  16'h8008, 8'd2, 15'h1FDB);
    run_window("after_latch", 16'h0010, 8'd1, 15'h1F86);
    run_window("eight",       16'h5555, 8'd8, 15'h1FFF);

    // en dropped after 3 edges: no strobe, rate holds
    for (int i = 0; i < 8; i++) begin
      spike_in = (i == 1 || i == 3 || i == 5);
      tick();
    end
    en = 1'b0; spike_in = 1'b0;
    cnt = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (rate_valid) cnt++;
    end
    chk_eq("en_drop_valid", cnt, 0);
    chk_eq("en_drop_rate", {24'd0, rate_count}, 8);
    chk_eq("en_drop_state", {30'd0, state_dbg}, {30'd0, IDLE});

    // Re-enable with an edge in the IDLE cycle: that edge is not counted
    en = 1'b1; spike_in = 1'b1;
    tick();
    run_window("idle_edge", 16'h0014, 8'd2, 15'h1FDB);

    // Reset mid-window aborts without a strobe
    for (int i = 0; i < 6; i++) begin
      spike_in = (i % 2 == 0);
      tick();
    end
    rst = 1'b1; spike_in = 1'b0;
    repeat (3) tick();
    chk_eq("midrst_rate", {24'd0, rate_count}, 0);
    chk_eq("midrst_seg", {17'd0, seg_out}, 32'h1FBF);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rate_valid) cnt++;
    end
    chk_eq("midrst_valid", cnt, 0);

`ifdef SPIKE_DECODER_ISI_EN
    // Edges 7 cycles apart; the first edge after reset does not update last_isi
    hold_reset();
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      spike_in = (i == 2 || i == 9);
      tick();
      if (i == 5) chk_eq("isi_first", {16'd0, last_isi}, 0);
    end
    chk_eq("isi_seven", {16'd0, last_isi}, 7);
`endif

    // Saturation on the WINDOW=1024 instance, then recovery
    hold_reset();
    start_run();
    cnt = 0;
    for (int i = 0; i < 1024; i++) begin
      spike_in = (i < 600 && i % 2 == 0);
      tick();
      if (i < 1023 && big_rate_valid) cnt++;
    end
    chk_eq("sat_early_valid", cnt, 0);
    chk_eq("sat_valid", {31'd0, big_rate_valid}, 1);
    chk_eq("sat_rate", {24'd0, big_rate_count}, 32'hFF);
    chk_eq("sat_seg", {17'd0, big_seg_out}, 32'h78F1);
    for (int i = 0; i < 1024; i++) begin
      spike_in = (i == 5 || i == 10);
      tick();
    end
    chk_eq("unsat_valid", {31'd0, big_rate_valid}, 1);
    chk_eq("unsat_rate", {24'd0, big_rate_count}, 2);
    chk_eq("unsat_seg", {17'd0, big_seg_out}, 32'h1FDB);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
